// File: rtl/stump_mem_bridge_pkg.sv
// Shared encodings for the Stump memory bridge: FSM states, transaction kinds,
// watchdog counter width and the start-strobe decode.
package stump_mem_bridge_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned KIND_W  = 2;
    localparam int unsigned CNT_W   = 8;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    localparam logic [KIND_W-1:0] KIND_FETCH = 2'd0;
    localparam logic [KIND_W-1:0] KIND_LOAD  = 2'd1;
    localparam logic [KIND_W-1:0] KIND_STORE = 2'd2;

    // Fetch has priority over a memory access; a load has priority over a store.
    function automatic logic [KIND_W-1:0] start_kind(input logic fetch, input logic mem_ren);
        if (fetch)
            return KIND_FETCH;
        else if (mem_ren)
            return KIND_LOAD;
        else
            return KIND_STORE;
    endfunction

endpackage

// File: rtl/stump_mem_watchdog.sv
// Wait-cycle counter for the bridge. Clears at transaction start, advances on
// each WAIT cycle without ack, and flags the last permitted WAIT cycle.
//   clk, rst    : clock, async active-low reset
//   clear       : zero the counter
//   enable      : increment the counter
//   expired_c   : counter has reached TIMEOUT-1 (combinational)
module stump_mem_watchdog
    import stump_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign expired_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/stump_mem_bridge.sv
// Memory-side bridge for Stump_control: converts fetch/memory phase strobes into
// a single req/ack bus transaction, returns fetched words on ir and loaded words
// on read_data, stalls the core while the bus is busy, and aborts stuck
// transactions with a sticky bus_err.
//   fetch, memory, mem_ren, mem_wen : phase strobes from control
//   address, data_out               : datapath address and store data
//   ir, read_data                   : captured instruction / load data
//   stall                           : combinational hold for control/datapath
//   bus_req/we/addr/wdata           : registered bus command
//   bus_rdata, bus_ack              : bus response
//   bus_err                         : sticky watchdog error
module stump_mem_bridge
    import stump_mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              memory,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [KIND_W-1:0]  kind_q;
    logic               start_c;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expired;

    assign start_c = fetch | (memory & (mem_ren | mem_wen));

    stump_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear     (wd_clear),
        .enable    (wd_enable),
        .expired_c (wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state, stall and watchdog control
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    stall    = 1'b1;
                    wd_clear = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                // Ack takes precedence over an expiring watchdog.
                if (bus_ack || wd_expired)
                    state_d = ST_DONE;
                else
                    wd_enable = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus command latch, response capture and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q    <= KIND_FETCH;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            ir        <= '0;
            read_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        kind_q    <= start_kind(fetch, mem_ren);
                        bus_req   <= 1'b1;
                        bus_we    <= (start_kind(fetch, mem_ren) == KIND_STORE);
                        bus_addr  <= address;
                        bus_wdata <= data_out;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (kind_q == KIND_FETCH)
                            ir <= bus_rdata;
                        else if (kind_q == KIND_LOAD)
                            read_data <= bus_rdata;
                    end else if (wd_expired) begin
                        // Abort returns zero so control sees a defined word.
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (kind_q == KIND_FETCH)
                            ir <= '0;
                        else if (kind_q == KIND_LOAD)
                            read_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stump_mem_bridge.sv
// Self-checking bench for stump_mem_bridge with a transaction scoreboard.
module tb_stump_mem_bridge;

    logic        clk;
    logic        rst;
    logic        fetch;
    logic        memory;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] ir;
    logic [15:0] read_data;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks;
    int failures;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] result;
        logic        err;
    } txn_t;

    txn_t sb[$];

    logic [15:0] exp_ir;
    logic [15:0] exp_rd;
    logic        exp_err;

    stump_mem_bridge #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .memory    (memory),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .address   (address),
        .data_out  (data_out),
        .ir        (ir),
        .read_data (read_data),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind: 0 fetch, 1 load, 2 store. ack_at is the WAIT cycle index carrying
    // bus_ack, or -1 for no ack at all.
    task automatic run_txn(input string name, input int kind, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int ack_at, input int exp_stall, input int exp_req);
        txn_t t;
        int   stall_n;
        int   req_n;
        bit   bad_bus;
        bit   done;
        @(negedge clk);
        fetch    = (kind == 0);
        memory   = (kind != 0);
        mem_ren  = (kind == 1);
        mem_wen  = (kind == 2);
        address  = addr;
        data_out = wdata;
        bus_rdata = rdata;
        bus_ack  = 1'b0;
        t.kind   = kind;
        t.addr   = addr;
        t.we     = (kind == 2);
        t.wdata  = wdata;
        t.result = (ack_at >= 0) ? rdata : 16'h0000;
        t.err    = (ack_at < 0);
        sb.push_back(t);
        #1;
        stall_n = stall ? 1 : 0;
        req_n   = 0;
        bad_bus = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_req) begin
                req_n++;
                if (bus_addr !== addr || bus_we !== t.we || (t.we && bus_wdata !== wdata))
                    bad_bus = 1'b1;
                bus_ack = (c == ack_at);
                #1;
                if (stall) stall_n++;
            end else begin
                done = 1'b1;
                bus_ack = 1'b0;
                #1;
                // Strobes are still high here: DONE must not stall or restart.
                checks++;
                if (stall !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_stall got=%b want=0", name, stall);
                end
            end
        end
        fetch   = 1'b0;
        memory  = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        bus_ack = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s completion got=timeout_bound want=done", name);
        end
        checks++;
        if (stall_n != exp_stall) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d want=%0d", name, stall_n, exp_stall);
        end
        checks++;
        if (req_n != exp_req) begin
            failures++;
            $display("FAIL %s req_cycles got=%0d want=%0d", name, req_n, exp_req);
        end
        checks++;
        if (bad_bus) begin
            failures++;
            $display("FAIL %s bus_cmd got=unstable_or_wrong want=addr=%h we=%b wdata=%h",
                     name, addr, t.we, wdata);
        end
        t = sb.pop_front();
        if (t.kind == 0) exp_ir = t.result;
        if (t.kind == 1) exp_rd = t.result;
        if (t.err) exp_err = 1'b1;
        checks++;
        if (ir !== exp_ir) begin
            failures++;
            $display("FAIL %s ir got=%h want=%h", name, ir, exp_ir);
        end
        checks++;
        if (read_data !== exp_rd) begin
            failures++;
            $display("FAIL %s read_data got=%h want=%h", name, read_data, exp_rd);
        end
        checks++;
        if (bus_err !== exp_err) begin
            failures++;
            $display("FAIL %s bus_err got=%b want=%b", name, bus_err, exp_err);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch = 1'b0; memory = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        address = 16'h0; data_out = 16'h0; bus_rdata = 16'h0; bus_ack = 1'b0;
        exp_ir = 16'h0; exp_rd = 16'h0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_err, stall} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {bus_req, bus_we, bus_err, stall});
        end
        checks++;
        if ({ir, read_data, bus_addr, bus_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {ir, read_data, bus_addr, bus_wdata});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        run_txn("fetch", 0, 16'h0010, 16'h0000, 16'hC123, 0, 2, 1);
    endtask

    task automatic test_load();
        run_txn("load", 1, 16'h0200, 16'h0000, 16'h55AA, 3, 5, 4);
    endtask

    task automatic test_store();
        run_txn("store", 2, 16'h0300, 16'hBEEF, 16'h1234, 1, 3, 2);
    endtask

    task automatic test_race();
        run_txn("race_ack_last", 0, 16'h0420, 16'h0000, 16'hA5F0, 14, 16, 15);
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        bus_rdata = 16'hDEAD;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, stall} !== 2'b00 || ir !== exp_ir || read_data !== exp_rd) begin
            failures++;
            $display("FAIL ack_idle got=req%b stall%b ir=%h rd=%h want=req0 stall0 ir=%h rd=%h",
                     bus_req, stall, ir, read_data, exp_ir, exp_rd);
        end
    endtask

    task automatic test_timeout();
        run_txn("timeout", 0, 16'h0500, 16'h0000, 16'h7777, -1, 16, 15);
        run_txn("fetch_after_err", 0, 16'h0502, 16'h0000, 16'h3C3C, 2, 4, 3);
        run_txn("load_after_err", 1, 16'h0600, 16'h0000, 16'h9001, 0, 2, 1);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        fetch   = 1'b1;
        address = 16'h0700;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL midwait_req got=%b want=1", bus_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_err} !== 2'b00 || {ir, read_data, bus_addr} !== 48'h0) begin
            failures++;
            $display("FAIL midwait_reset got=req%b err%b ir=%h rd=%h addr=%h want=all zero",
                     bus_req, bus_err, ir, read_data, bus_addr);
        end
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall_follows_start got=%b want=1", stall);
        end
        fetch = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_idle got=%b want=0", stall);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_ir = 16'h0; exp_rd = 16'h0; exp_err = 1'b0;
        sb.delete();
        run_txn("fetch_after_reset", 0, 16'h0800, 16'h0000, 16'h0F0F, 1, 3, 2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_race();
        test_ack_idle();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
